// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator controller.
package calc_pkg;

  // Width of the ALU-completion timeout counter.
  localparam int TMO_W = 8;

  // Default number of WAIT_DONE cycles before giving up on the ALU.
  localparam logic [TMO_W-1:0] TIMEOUT_DEF = 8'd200;

  // Sign-magnitude "-0", shown on the display when an operation fails.
  localparam logic [7:0] ERR_CODE_DEF = 8'h80;

  // Controller states (binary encoded).
  typedef enum logic [2:0] {
    ST_GET_A     = 3'd0,
    ST_GET_B     = 3'd1,
    ST_START     = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_SHOW      = 3'd4,
    ST_ERR       = 3'd5
  } state_t;

  // Operation codes understood by the external ALU.
  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_DIV = 2'd3
  } alu_op_t;

  // True while an ALU operation is being launched or awaited.
  function automatic logic state_is_busy(input state_t s);
    return (s == ST_START) || (s == ST_WAIT_DONE);
  endfunction

endpackage

// File: rtl/calc_timeout.sv
// Clearable up-counter with a terminal flag, used to bound the wait for the ALU.
module calc_timeout
  import calc_pkg::*;
#(
  parameter int W = TMO_W
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_clr,
  input  logic         i_en,
  input  logic [W-1:0] i_limit,
  output logic         o_term
);

  logic [W-1:0] r_count;

  // Count enabled cycles; clear has priority over counting.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + 1'b1;
    end
  end

  // Terminal flag is high for the whole cycle in which the count equals the limit.
  assign o_term = (r_count == i_limit);

endmodule

// File: rtl/calc_ctrl.sv
// Calculator controller: collects two operands from switches, runs the external
// ALU, and drives the display unit with operands, results or an error code.
module calc_ctrl
  import calc_pkg::*;
#(
  parameter logic [TMO_W-1:0] TIMEOUT  = TIMEOUT_DEF,
  parameter logic [7:0]       ERR_CODE = ERR_CODE_DEF
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_key_enter,
  input  logic [7:0] i_sw,
  input  logic [1:0] i_op_sel,
  input  logic [7:0] i_alu_result,
  input  logic       i_alu_done,
  input  logic       i_alu_ovf,
  output logic [7:0] o_op_a,
  output logic [7:0] o_op_b,
  output logic [1:0] o_alu_op,
  output logic       o_alu_start,
  output logic [7:0] o_disp_val,
  output logic       o_load_ou,
  output logic       o_busy,
  output logic       o_err
);

  state_t     r_state;
  logic       r_key_d;
  logic [7:0] r_op_a;
  logic [7:0] r_op_b;
  alu_op_t    r_alu_op;
  logic [7:0] r_disp_val;
  logic       r_alu_start;
  logic       r_load_ou;

  state_t     w_state_next;
  logic       w_key_pulse;
  logic       w_term;
  logic       w_cnt_clr;
  logic       w_cnt_en;
  logic       w_op_a_ld;
  logic [7:0] w_op_a_next;
  logic       w_op_b_ld;
  logic       w_alu_op_ld;
  logic       w_disp_ld;
  logic [7:0] w_disp_next;
  logic       w_start_next;
  logic       w_load_next;

  // A key press is accepted only on its first high cycle, so a held key counts once.
  assign w_key_pulse = i_key_enter & ~r_key_d;

  calc_timeout #(
    .W(TMO_W)
  ) u_timeout (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_clr  (w_cnt_clr),
    .i_en   (w_cnt_en),
    .i_limit(TIMEOUT),
    .o_term (w_term)
  );

  // Remember the previous key level for edge detection.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_key_d <= 1'b0;
    end else begin
      r_key_d <= i_key_enter;
    end
  end

  // Next-state and datapath-control decode.
  always_comb begin
    w_state_next = r_state;
    w_cnt_clr    = 1'b0;
    w_cnt_en     = 1'b0;
    w_op_a_ld    = 1'b0;
    w_op_a_next  = r_op_a;
    w_op_b_ld    = 1'b0;
    w_alu_op_ld  = 1'b0;
    w_disp_ld    = 1'b0;
    w_disp_next  = r_disp_val;
    w_start_next = 1'b0;
    w_load_next  = 1'b0;

    case (r_state)
      ST_GET_A: begin
        if (w_key_pulse) begin
          w_op_a_ld    = 1'b1;
          w_op_a_next  = i_sw;
          w_disp_ld    = 1'b1;
          w_disp_next  = i_sw;
          w_load_next  = 1'b1;
          w_state_next = ST_GET_B;
        end
      end

      ST_GET_B: begin
        if (w_key_pulse) begin
          w_op_b_ld    = 1'b1;
          w_alu_op_ld  = 1'b1;
          w_disp_ld    = 1'b1;
          w_disp_next  = i_sw;
          w_load_next  = 1'b1;
          w_state_next = ST_START;
        end
      end

      // The start pulse is registered, so it appears in the first WAIT_DONE cycle.
      ST_START: begin
        w_cnt_clr    = 1'b1;
        w_start_next = 1'b1;
        w_state_next = ST_WAIT_DONE;
      end

      // A completion in the terminal cycle is still honoured: done is checked first.
      ST_WAIT_DONE: begin
        w_cnt_en = 1'b1;
        if (i_alu_done) begin
          w_disp_ld   = 1'b1;
          w_load_next = 1'b1;
          if (i_alu_ovf) begin
            w_disp_next  = ERR_CODE;
            w_state_next = ST_ERR;
          end else begin
            w_disp_next  = i_alu_result;
            w_state_next = ST_SHOW;
          end
        end else if (w_term) begin
          w_disp_ld    = 1'b1;
          w_disp_next  = ERR_CODE;
          w_load_next  = 1'b1;
          w_state_next = ST_ERR;
        end
      end

      // Chaining: the displayed result (latched ALU output) becomes operand A.
      ST_SHOW: begin
        if (w_key_pulse) begin
          w_op_a_ld    = 1'b1;
          w_op_a_next  = r_disp_val;
          w_state_next = ST_GET_B;
        end
      end

      ST_ERR: begin
        if (w_key_pulse) begin
          w_state_next = ST_GET_A;
        end
      end

      default: begin
        w_state_next = ST_GET_A;
      end
    endcase
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_GET_A;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Operand, op-code and display registers hold until explicitly reloaded.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_op_a     <= '0;
      r_op_b     <= '0;
      r_alu_op   <= OP_ADD;
      r_disp_val <= '0;
    end else begin
      if (w_op_a_ld) begin
        r_op_a <= w_op_a_next;
      end
      if (w_op_b_ld) begin
        r_op_b <= i_sw;
      end
      if (w_alu_op_ld) begin
        r_alu_op <= alu_op_t'(i_op_sel);
      end
      if (w_disp_ld) begin
        r_disp_val <= w_disp_next;
      end
    end
  end

  // Registered strobes; the load strobe is never allowed on two consecutive cycles.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_alu_start <= 1'b0;
      r_load_ou   <= 1'b0;
    end else begin
      r_alu_start <= w_start_next;
      r_load_ou   <= w_load_next & ~r_load_ou;
    end
  end

  assign o_op_a      = r_op_a;
  assign o_op_b      = r_op_b;
  assign o_alu_op    = r_alu_op;
  assign o_alu_start = r_alu_start;
  assign o_disp_val  = r_disp_val;
  assign o_load_ou   = r_load_ou;
  assign o_busy      = state_is_busy(r_state);
  assign o_err       = (r_state == ST_ERR);

endmodule

// File: tb/tb_calc_ctrl.sv
// Directed testbench for calc_ctrl.
module tb_calc_ctrl;

  logic       clk;
  logic       rst_n;
  logic       key;
  logic [7:0] sw;
  logic [1:0] op_sel;
  logic [7:0] alu_result;
  logic       alu_done;
  logic       alu_ovf;
  logic [7:0] op_a;
  logic [7:0] op_b;
  logic [1:0] alu_op;
  logic       alu_start;
  logic [7:0] disp_val;
  logic       load_ou;
  logic       busy;
  logic       err;

  int checks;
  int failures;
  int load_cnt;
  int load_consec;
  logic load_prev;
  int base;
  int n;

  calc_ctrl #(
    .TIMEOUT (8'd200),
    .ERR_CODE(8'h80)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_key_enter (key),
    .i_sw        (sw),
    .i_op_sel    (op_sel),
    .i_alu_result(alu_result),
    .i_alu_done  (alu_done),
    .i_alu_ovf   (alu_ovf),
    .o_op_a      (op_a),
    .o_op_b      (op_b),
    .o_alu_op    (alu_op),
    .o_alu_start (alu_start),
    .o_disp_val  (disp_val),
    .o_load_ou   (load_ou),
    .o_busy      (busy),
    .o_err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count display strobes and flag any back-to-back pair.
  initial begin
    load_cnt    = 0;
    load_consec = 0;
    load_prev   = 1'b0;
    forever begin
      @(negedge clk);
      if (load_ou === 1'b1) begin
        load_cnt++;
        if (load_prev === 1'b1) load_consec++;
      end
      load_prev = load_ou;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %-16s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic enter();
    key = 1'b1;
    tick();
    key = 1'b0;
  endtask

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b0; key = 1'b0; sw = '0; op_sel = '0;
    alu_result = '0; alu_done = 1'b0; alu_ovf = 1'b0;

    // Reset state
    #2;
    chk("rst_op_a", op_a, 0);
    chk("rst_op_b", op_b, 0);
    chk("rst_disp", disp_val, 0);
    chk("rst_load", load_ou, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_start", alu_start, 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("rel_load", load_ou, 0);
    chk("rel_busy", busy, 0);

    // Scenario 1: 5 + 3
    base = load_cnt;
    sw = 8'h05; enter();
    chk("s1_op_a", op_a, 8'h05);
    chk("s1_disp_a", disp_val, 8'h05);
    chk("s1_load_a", load_ou, 1);
    tick();
    chk("s1_load_a_off", load_ou, 0);
    sw = 8'h03; op_sel = 2'd0; enter();
    chk("s1_op_b", op_b, 8'h03);
    chk("s1_start_1cyc", alu_start, 0);
    chk("s1_busy", busy, 1);
    tick();
    chk("s1_start_2cyc", alu_start, 1);
    chk("s1_alu_op", alu_op, 0);
    tick();
    chk("s1_start_off", alu_start, 0);
    tick(); tick();
    alu_result = 8'h08; alu_done = 1'b1;
    tick();
    alu_done = 1'b0;
    chk("s1_disp_res", disp_val, 8'h08);
    chk("s1_load_res", load_ou, 1);
    chk("s1_busy_off", busy, 0);
    tick();
    chk("s1_loads", load_cnt - base, 3);

    // Scenario 4: chain result into operand A
    enter();
    chk("s4_op_a", op_a, 8'h08);
    chk("s4_no_load", load_ou, 0);
    chk("s4_disp_hold", disp_val, 8'h08);
    tick();
    base = load_cnt;
    sw = 8'h02; op_sel = 2'd1; enter();
    chk("s4_op_b", op_b, 8'h02);
    chk("s4_op_a_keep", op_a, 8'h08);
    chk("s4_disp_b", disp_val, 8'h02);
    tick();
    chk("s4_start", alu_start, 1);
    chk("s4_alu_op", alu_op, 1);

    // Scenario 5: key presses while waiting are ignored
    key = 1'b1; tick(); key = 1'b0; tick();
    key = 1'b1; tick(); key = 1'b0; tick();
    chk("s5_busy", busy, 1);
    alu_result = 8'h0A; alu_done = 1'b1;
    tick();
    alu_done = 1'b0;
    chk("s5_disp", disp_val, 8'h0A);
    chk("s5_op_a", op_a, 8'h08);
    chk("s5_op_b", op_b, 8'h02);
    tick();
    chk("s5_loads", load_cnt - base, 2);

    // Scenario 2: overflow -> ERR
    enter();
    tick();
    sw = 8'h07; op_sel = 2'd2; enter();
    tick();
    base = load_cnt;
    chk("s2_start", alu_start, 1);
    chk("s2_alu_op", alu_op, 2);
    tick();
    alu_result = 8'hFF; alu_ovf = 1'b1; alu_done = 1'b1;
    tick();
    alu_done = 1'b0; alu_ovf = 1'b0;
    chk("s2_err", err, 1);
    chk("s2_disp", disp_val, 8'h80);
    chk("s2_load", load_ou, 1);
    chk("s2_busy", busy, 0);
    tick();
    chk("s2_load_off", load_ou, 0);
    chk("s2_loads", load_cnt - base, 1);
    enter();
    chk("s2_err_clr", err, 0);
    chk("s2_disp_hold", disp_val, 8'h80);
    chk("s2_op_a_hold", op_a, 8'h0A);
    chk("s2_no_load", load_ou, 0);
    tick();

    // Held key counts only once
    sw = 8'h11; key = 1'b1;
    tick();
    chk("hold_op_a", op_a, 8'h11);
    tick(); tick();
    sw = 8'h99;
    tick();
    key = 1'b0;
    tick();
    chk("hold_busy", busy, 0);
    chk("hold_op_b", op_b, 8'h07);

    // Scenario 3: timeout
    sw = 8'h22; op_sel = 2'd3; enter();
    tick();
    chk("s3_start", alu_start, 1);
    n = 0;
    while (err !== 1'b1 && n < 400) begin
      tick();
      n++;
    end
    chk("s3_cycles", n, 201);
    chk("s3_disp", disp_val, 8'h80);
    chk("s3_load", load_ou, 1);
    enter();
    tick();

    // Done in the same cycle the timeout would fire: done wins
    sw = 8'h10; enter(); tick();
    sw = 8'h20; enter(); tick();
    chk("tw_start", alu_start, 1);
    repeat (200) tick();
    chk("tw_no_err_yet", err, 0);
    alu_result = 8'h33; alu_done = 1'b1;
    tick();
    alu_done = 1'b0;
    chk("tw_err", err, 0);
    chk("tw_disp", disp_val, 8'h33);
    chk("tw_busy", busy, 0);

    // Scenario 6: asynchronous reset in WAIT_DONE
    enter(); tick();
    sw = 8'h01; enter();
    tick();
    chk("s6_busy_pre", busy, 1);
    chk("s6_alu_op_pre", alu_op, 3);
    #3;
    rst_n = 1'b0;
    #1;
    chk("s6_op_a", op_a, 0);
    chk("s6_op_b", op_b, 0);
    chk("s6_alu_op", alu_op, 0);
    chk("s6_disp", disp_val, 0);
    chk("s6_start", alu_start, 0);
    chk("s6_load", load_ou, 0);
    chk("s6_busy", busy, 0);
    tick();
    rst_n = 1'b1;
    tick();
    alu_result = 8'h55; alu_done = 1'b1;
    tick();
    alu_done = 1'b0;
    chk("s6_late_busy", busy, 0);
    chk("s6_late_err", err, 0);
    chk("s6_late_disp", disp_val, 0);
    chk("s6_late_load", load_ou, 0);
    tick();
    sw = 8'h44; enter();
    chk("s6_get_a", op_a, 8'h44);
    chk("s6_get_a_disp", disp_val, 8'h44);
    tick();

    chk("load_consec", load_consec, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/calc_ctrl.md
CALC_CTRL -- requirements
Module: calc_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 8'd200: maximum cycles to wait for alu_done before declaring an error.
REQ-002 Parameter ERR_CODE, default 8'h80: value driven on disp_val in the error state (sign-magnitude "-0").
REQ-003 clock  in  1  single system clock; all state changes on rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 key_enter  in  1  single-cycle pulse from an external debouncer; ignored while high for more than one cycle.
REQ-006 sw  in  8  operand switches, sign-magnitude.
REQ-007 op_sel  in  2  operation select; sampled with operand B.
REQ-008 alu_result  in  8  result from the external ALU.
REQ-009 alu_done  in  1  single-cycle completion pulse from the ALU.
REQ-010 alu_ovf  in  1  overflow flag; valid only in the alu_done cycle.
REQ-011 opA, opB  out  8 each  registered operands to the ALU.
REQ-012 alu_op  out  2  registered operation code.
REQ-013 alu_start  out  1  single-cycle start pulse.
REQ-014 disp_val  out  8  value presented to the output display unit.
REQ-015 LoadOU  out  1  single-cycle load strobe; the display unit captures disp_val on it.
REQ-016 busy  out  1  high in START and WAIT_DONE.
REQ-017 err  out  1  high in ERR.

Function
REQ-018 States: GET_A, GET_B, START, WAIT_DONE, SHOW, ERR; the state encoding is a one-hot or binary enum from the package.
REQ-019 GET_A + key_enter -> opA<=sw, disp_val<=sw, LoadOU pulses the next cycle, go to GET_B.
REQ-020 GET_B + key_enter -> opB<=sw, alu_op<=op_sel, disp_val<=sw, LoadOU pulses, go to START.
REQ-021 START: alu_start=1 for exactly one cycle, timeout counter cleared, unconditional transition to WAIT_DONE.
REQ-022 WAIT_DONE: counter increments every cycle; alu_done && !alu_ovf -> disp_val<=alu_result, LoadOU pulses, go to SHOW.
REQ-023 WAIT_DONE: alu_done && alu_ovf -> go to ERR.
REQ-024 WAIT_DONE: counter reaching TIMEOUT without alu_done -> go to ERR.
REQ-025 alu_done and timeout in the same cycle: alu_done wins.
REQ-026 ERR entry: disp_val<=ERR_CODE and LoadOU pulses once.
REQ-027 ERR and SHOW: key_enter -> go to GET_A; opA, opB and disp_val are held until overwritten.
REQ-028 SHOW + key_enter is chaining: opA<=alu_result, go to GET_B, no LoadOU.
REQ-029 REQ-027 applies to ERR only; REQ-028 governs key_enter in SHOW.
REQ-030 key_enter in START or WAIT_DONE is ignored; it is neither queued nor counted.
REQ-031 alu_done outside WAIT_DONE is ignored.
REQ-032 LoadOU is registered, one cycle after the event that causes it, and never high on two consecutive cycles.
REQ-033 Latency from key_enter in GET_B to alu_start is 2 cycles.

Reset
REQ-034 On reset low, all outputs and registers are cleared immediately (asynchronously): state=GET_A, opA=opB=0, alu_op=0, disp_val=0, alu_start=0, LoadOU=0, busy=0, err=0, counter=0.
REQ-035 Reset asserted mid-operation (any state) aborts the operation; a late alu_done after release is ignored per REQ-031.
REQ-036 First state after reset release is GET_A; no LoadOU is issued at release.

Structure
REQ-037 Package calc_pkg holds the state enum, the op codes (ADD=0, SUB=1, MUL=2, DIV=3), the default ERR_CODE and the timeout width.
REQ-038 One sub-module, calc_timeout, an 8-bit clearable counter with a terminal flag; the rest is a single FSM.

Verification
REQ-039 Scenario 1: sw=8'h05 enter, sw=8'h03 op=ADD enter, alu_done with result 8'h08 after 4 cycles -> alu_start 2 cycles after the second enter; disp_val=8'h08; three LoadOU pulses total.
REQ-040 Scenario 2: alu_done with alu_ovf=1 -> err=1, disp_val=8'h80, one LoadOU pulse; enter -> GET_A with err=0.
REQ-041 Scenario 3: no alu_done -> ERR exactly TIMEOUT+1 cycles after alu_start.
REQ-042 Scenario 4: SHOW with result 8'h08, enter, sw=8'h02 enter -> opA=8'h08, opB=8'h02.
REQ-043 Scenario 5: enter pulses during WAIT_DONE, then alu_done -> SHOW, opA and opB unchanged, no extra LoadOU.
REQ-044 Scenario 6: reset driven low in WAIT_DONE between clock edges -> outputs zero before the next edge; alu_done pulse after release -> state stays GET_A.
